// File: rtl/disp_scan_pkg.sv
// Shared display definitions: letter codes for the segment decoder and the
// scanner state encoding.
package disp_scan_pkg;

    typedef logic [3:0] code_t;

    localparam code_t CODE_BLANK = 4'b0000;
    localparam code_t CODE_A     = 4'b0001;
    localparam code_t CODE_B     = 4'b0010;
    localparam code_t CODE_C     = 4'b0011;
    localparam code_t CODE_D     = 4'b0100;
    localparam code_t CODE_E     = 4'b0101;
    localparam code_t CODE_F     = 4'b0110;
    localparam code_t CODE_G     = 4'b0111;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage

// File: rtl/disp_scan_timer.sv
// Slot counter shared by the lit and blanking phases: counts 0..i_limit,
// flags the terminal count and wraps back to zero on the following edge.
module scan_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    assign o_tc = (r_cnt == i_limit);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (o_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed 7-segment scanner with a dark interval between
// digits; every output is registered from next-cycle state.
module disp_scan
    import disp_scan_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int DEAD    = 500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_en,
    input  logic [1:0] i_wr_addr,
    input  code_t      i_wr_data,
    input  logic [3:0] i_en_mask,
    output code_t      o_code,
    output logic [3:0] o_digit_n,
    output logic       o_frame
);

    localparam int CMAX = (CLK_DIV > DEAD) ? CLK_DIV : DEAD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] LIM_SHOW  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LIM_BLANK = CW'(DEAD - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_next;
    logic        w_wrap;
    logic        w_tc;
    logic [CW-1:0] w_limit;
    logic [3:0]  w_digit_n_next;
    logic [3:0]  w_dig_we;
    code_t       r_dig [4];
    code_t       r_code;
    logic [3:0]  r_digit_n;
    logic        r_frame;

    assign w_limit = (r_state == ST_SHOW) ? LIM_SHOW : LIM_BLANK;

    scan_timer #(
        .W(CW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_limit (w_limit),
        .o_tc    (w_tc)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign w_dig_we[gi] = i_wr_en && (i_wr_addr == 2'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!i_rst_n) begin
                r_dig[i] <= CODE_BLANK;
            end else if (w_dig_we[i]) begin
                r_dig[i] <= i_wr_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_wrap       = 1'b0;
        if (w_tc) begin
            if (r_state == ST_BLANK) begin
                w_state_next = ST_SHOW;
            end else begin
                w_state_next = ST_BLANK;
                w_idx_next   = r_idx + 2'd1;
                w_wrap       = (r_idx == 2'd3);
            end
        end
        // Select pattern follows the upcoming state so the output register lines up.
        w_digit_n_next = 4'b1111;
        if (w_state_next == ST_SHOW) begin
            w_digit_n_next[w_idx_next] = ~i_en_mask[w_idx_next];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_BLANK;
            r_idx     <= 2'd0;
            r_code    <= CODE_BLANK;
            r_digit_n <= 4'b1111;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_code    <= r_dig[w_idx_next];
            r_digit_n <= w_digit_n_next;
            r_frame   <= w_wrap;
        end
    end

    assign o_code    = r_code;
    assign o_digit_n = r_digit_n;
    assign o_frame   = r_frame;

endmodule

// File: tb/tb_disp_scan.sv
// Randomized and directed bench for disp_scan; a cycle-position model derives
// every expected output from elapsed cycles since reset.
module tb_disp_scan;

    localparam int CD    = 4;
    localparam int DD    = 2;
    localparam int SLOT  = CD + DD;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [3:0] wr_data;
    logic [3:0] en_mask;
    logic [3:0] o_code;
    logic [3:0] o_digit_n;
    logic       o_frame;

    int n_checks = 0;
    int n_fail   = 0;

    int         t = 0;
    logic [3:0] m_dig [4];
    logic [3:0] e_code;
    logic [3:0] e_dn;
    logic       e_frame;
    logic [3:0] prev_dn = 4'hF;

    always #5 clk = ~clk;

    disp_scan #(
        .CLK_DIV(CD),
        .DEAD   (DD)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_en_mask (en_mask),
        .o_code    (o_code),
        .o_digit_n (o_digit_n),
        .o_frame   (o_frame)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare just after it.
    task automatic step();
        logic [3:0] old_dig [4];
        int ix;
        @(posedge clk);
        if (!rst_n) begin
            t = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
            e_code  = 4'h0;
            e_dn    = 4'hF;
            e_frame = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) old_dig[i] = m_dig[i];
            if (wr_en) m_dig[wr_addr] = wr_data;
            t++;
            ix      = (t / SLOT) % 4;
            e_code  = old_dig[ix];
            e_dn    = 4'hF;
            if ((t % SLOT) >= DD) e_dn[ix] = ~en_mask[ix];
            e_frame = ((t % FRAME) == 0);
        end
        #1;
        check("code", 32'(o_code), 32'(e_code));
        check("digit_n", 32'(o_digit_n), 32'(e_dn));
        check("frame", 32'(o_frame), 32'(e_frame));
        check("one_low", 32'($countones(~o_digit_n) <= 1), 32'(1));
        if (o_digit_n != 4'hF && prev_dn != 4'hF)
            check("dark_gap", 32'(o_digit_n), 32'(prev_dn));
        prev_dn = o_digit_n;
    endtask

    task automatic run_until(input int pos);
        for (int k = 0; k <= FRAME; k++) begin
            if ((t % FRAME) == pos) break;
            step();
        end
        check("run_until_pos", 32'(t % FRAME), 32'(pos));
    endtask

    initial begin
        int frames;
        int bad;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 4'h0;
        en_mask = 4'hF;
        repeat (3) step();
        check("rst_code", 32'(o_code), 32'h0);
        check("rst_dn", 32'(o_digit_n), 32'hF);
        check("rst_frame", 32'(o_frame), 32'h0);

        // Scan pattern after release with all digits enabled.
        rst_n = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 1)  check("lit_dn_t1", 32'(o_digit_n), 32'hF);
            if (c == 2)  check("lit_dn_t2", 32'(o_digit_n), 32'hE);
            if (c == 5)  check("lit_dn_t5", 32'(o_digit_n), 32'hE);
            if (c == 6)  check("lit_dn_t6", 32'(o_digit_n), 32'hF);
            if (c == 8)  check("lit_dn_t8", 32'(o_digit_n), 32'hD);
            if (c == 23) check("lit_frame_t23", 32'(o_frame), 32'h0);
            if (c == 24) check("lit_frame_t24", 32'(o_frame), 32'h1);
        end

        // Load four letters and check each appears in its own slot.
        for (int d = 0; d < 4; d++) begin
            wr_en   = 1'b1;
            wr_addr = 2'(d);
            wr_data = (d == 0) ? 4'h1 : (d == 1) ? 4'h4 : (d == 2) ? 4'h2 : 4'h3;
            step();
        end
        wr_en = 1'b0;
        repeat (FRAME) step();
        run_until(2);  check("lit_code_d0", 32'(o_code), 32'h1); check("lit_sel_d0", 32'(o_digit_n), 32'hE);
        run_until(8);  check("lit_code_d1", 32'(o_code), 32'h4); check("lit_sel_d1", 32'(o_digit_n), 32'hD);
        run_until(14); check("lit_code_d2", 32'(o_code), 32'h2); check("lit_sel_d2", 32'(o_digit_n), 32'hB);
        run_until(20); check("lit_code_d3", 32'(o_code), 32'h3); check("lit_sel_d3", 32'(o_digit_n), 32'h7);

        // Overwrite the digit currently lit.
        run_until(9);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h6;
        step();
        wr_en = 1'b0;
        check("lit_live_old", 32'(o_code), 32'h4);
        check("lit_live_sel0", 32'(o_digit_n), 32'hD);
        step();
        check("lit_live_new", 32'(o_code), 32'h6);
        check("lit_live_sel1", 32'(o_digit_n), 32'hD);

        // Masked digits stay dark; frame cadence unchanged.
        en_mask = 4'b0101;
        frames = 0; bad = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            step();
            if (o_frame) frames++;
            if (o_digit_n == 4'hD || o_digit_n == 4'h7) bad++;
        end
        check("lit_mask_frames", 32'(frames), 32'd2);
        check("lit_mask_dark", 32'(bad), 32'd0);
        en_mask = 4'hF;

        // Reset during digit 2 with a write pending: reset wins.
        run_until(15);
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h9;
        step();
        check("lit_rst_dn", 32'(o_digit_n), 32'hF);
        check("lit_rst_code", 32'(o_code), 32'h0);
        check("lit_rst_frame", 32'(o_frame), 32'h0);
        rst_n = 1'b1; wr_en = 1'b0;
        step();
        check("lit_rel_dn1", 32'(o_digit_n), 32'hF);
        step();
        check("lit_rel_dn2", 32'(o_digit_n), 32'hE);
        check("lit_rel_code", 32'(o_code), 32'h0);
        run_until(14);
        check("lit_rst_lost", 32'(o_code), 32'h0);

        // Randomized traffic, mask changes and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) en_mask = 4'($urandom_range(0, 15));
            rst_n   = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
